// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO controller slice.
// Optional feature macro: FIFO_CTRL_ERR_FLAGS_EN (undefined by default),
// which adds sticky OVERFLOW/UNDERFLOW flags.
package fifo_ctrl_pkg;

    // Default geometry: a 4-entry FIFO addressed with 2 bits.
    localparam int FIFO_ADDR_WIDTH_DEF = 2;
    localparam int FIFO_DEPTH_DEF      = 4;

    // Accepted-operation encoding, formed as {wr_acc, rd_acc}.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    // Pointer width: address bits plus one wrap bit.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    // DEPTH must be exactly 2**ADDR_WIDTH; the wrap-bit scheme relies on it.
    function automatic bit depth_ok(input int addr_width, input int depth);
        return (depth == (1 << addr_width));
    endfunction

endpackage

// File: rtl/fifo_ctrl_if.sv
// Handshake and RAM-control bundle between a FIFO user and fifo_ctrl.
// Optional feature macro: FIFO_CTRL_ERR_FLAGS_EN adds overflow/underflow.
interface fifo_ctrl_if #(
    parameter int ADDR_WIDTH = 2
);
    logic                  wr_req;
    logic                  rd_req;
    logic                  full;
    logic                  empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  ram_en_wr;
    logic [ADDR_WIDTH-1:0] ram_addr_wr;
    logic                  ram_en_rd;
    logic [ADDR_WIDTH-1:0] ram_addr_rd;
    logic                  rd_valid;
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    logic                  overflow;
    logic                  underflow;
`endif

    // Controller side: takes requests, drives status and RAM controls.
    modport slave (
        input  wr_req,
        input  rd_req,
        output full,
        output empty,
        output count,
        output ram_en_wr,
        output ram_addr_wr,
        output ram_en_rd,
        output ram_addr_rd,
        output rd_valid
`ifdef FIFO_CTRL_ERR_FLAGS_EN
        , output overflow
        , output underflow
`endif
    );

    // User side: issues requests, observes status.
    modport master (
        output wr_req,
        output rd_req,
        input  full,
        input  empty,
        input  count,
        input  ram_en_wr,
        input  ram_addr_wr,
        input  ram_en_rd,
        input  ram_addr_rd,
        input  rd_valid
`ifdef FIFO_CTRL_ERR_FLAGS_EN
        , input overflow
        , input underflow
`endif
    );

endinterface

// File: rtl/fifo_ptr.sv
// Wrap-bit FIFO pointer: ADDR_WIDTH+1 bits, increments on enable and wraps
// naturally modulo 2**PTR_WIDTH. Synchronous active-low reset.
module fifo_ptr #(
    parameter int PTR_WIDTH = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 inc_i,
    output logic [PTR_WIDTH-1:0] ptr_o
);

    logic [PTR_WIDTH-1:0] ptr_q;
    logic [PTR_WIDTH-1:0] ptr_d;

    // Next pointer: advance by one on an accepted transfer.
    always_comb begin
        ptr_d = ptr_q;
        if (inc_i) begin
            ptr_d = ptr_q + {{(PTR_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register with synchronous reset to zero.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            ptr_q <= {PTR_WIDTH{1'b0}};
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller sitting in front of a dual-port RAM with registered read
// data. Tracks pointers, occupancy and FULL/EMPTY, drives RAM enables and
// addresses, and flags when the RAM output holds a popped word.
// Optional feature macro: FIFO_CTRL_ERR_FLAGS_EN (sticky overflow/underflow).
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH_DEF,
    parameter int DEPTH      = FIFO_DEPTH_DEF
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    fifo_ctrl_if.slave       bus
);

    localparam int PTR_W = ptr_width(ADDR_WIDTH);

    if (!depth_ok(ADDR_WIDTH, DEPTH)) begin : g_bad_depth
        $error("fifo_ctrl: DEPTH must equal 2**ADDR_WIDTH");
    end

    logic             wr_acc_s;
    logic             rd_acc_s;
    fifo_op_e         op_s;
    logic [PTR_W-1:0] wr_ptr_s;
    logic [PTR_W-1:0] rd_ptr_s;
    logic [PTR_W-1:0] occ_s;
    logic [PTR_W-1:0] count_d;
    logic [PTR_W-1:0] count_q;
    logic             full_q;
    logic             empty_q;
    logic             rd_valid_q;

    // Accept decisions come only from registered flags, so a request never
    // reaches the flags combinationally.
    assign wr_acc_s = bus.wr_req & ~full_q;
    assign rd_acc_s = bus.rd_req & ~empty_q;
    assign op_s     = fifo_op_e'({wr_acc_s, rd_acc_s});

    fifo_ptr #(.PTR_WIDTH(PTR_W)) u_wr_ptr (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (wr_acc_s),
        .ptr_o   (wr_ptr_s)
    );

    fifo_ptr #(.PTR_WIDTH(PTR_W)) u_rd_ptr (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (rd_acc_s),
        .ptr_o   (rd_ptr_s)
    );

    // Pointer distance is the current occupancy; the wrap bit makes a full
    // FIFO read as DEPTH rather than 0.
    assign occ_s = wr_ptr_s - rd_ptr_s;

    // Next occupancy: +1 push only, -1 pop only, hold on both or neither.
    always_comb begin
        count_d = occ_s;
        case (op_s)
            OP_PUSH: count_d = occ_s + {{(PTR_W-1){1'b0}}, 1'b1};
            OP_POP:  count_d = occ_s - {{(PTR_W-1){1'b0}}, 1'b1};
            OP_BOTH: count_d = occ_s;
            OP_NONE: count_d = occ_s;
            default: count_d = occ_s;
        endcase
    end

    // Status registers: occupancy, flags from next occupancy, and read-valid
    // aligned with the RAM's registered output.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            count_q    <= {PTR_W{1'b0}};
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            rd_valid_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            full_q     <= (count_d == PTR_W'(DEPTH));
            empty_q    <= (count_d == {PTR_W{1'b0}});
            rd_valid_q <= rd_acc_s;
        end
    end

    // RAM enables are gated by reset so nothing is written or read while
    // the controller is being cleared.
    assign bus.ram_en_wr   = wr_acc_s & rst_n_i;
    assign bus.ram_en_rd   = rd_acc_s & rst_n_i;
    assign bus.ram_addr_wr = wr_ptr_s[ADDR_WIDTH-1:0];
    assign bus.ram_addr_rd = rd_ptr_s[ADDR_WIDTH-1:0];

    assign bus.count    = count_q;
    assign bus.full     = full_q;
    assign bus.empty    = empty_q;
    assign bus.rd_valid = rd_valid_q;

`ifdef FIFO_CTRL_ERR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;

    // Sticky error flags: set on a request against a blocking flag, held
    // until reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_q  | (bus.wr_req & full_q);
            underflow_q <= underflow_q | (bus.rd_req & empty_q);
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench: fifo_ctrl plus a behavioural 2-bit-wide dual-port RAM with
// registered read data. Expected read data is queued when a pop is issued and
// checked by a separate monitor whenever RD_VALID is high.
`timescale 1ns/1ps
module tb_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] d_in;
    logic [1:0] d_out;
    logic [1:0] mem [0:3];

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_q [$];

    fifo_ctrl_if #(.ADDR_WIDTH(2)) bus ();

    fifo_ctrl #(.ADDR_WIDTH(2), .DEPTH(4)) u_dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Behavioural dual-port RAM, DATA_WIDTH=2, registered read port.
    always @(posedge clk) begin
        if (bus.ram_en_wr === 1'b1) mem[bus.ram_addr_wr] <= d_in;
        if (bus.ram_en_rd === 1'b1) d_out <= mem[bus.ram_addr_rd];
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    // Monitor: every presented word must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_valid_unexpected actual 1 required 0");
            end else begin
                chk("d_out", {6'd0, d_out}, {6'd0, exp_q.pop_front()});
            end
        end
    end

    // One clock of stimulus with hand-computed expectations.
    task automatic step(input logic wr, input logic rd, input logic [1:0] din,
                        input logic ew, input logic er,
                        input logic [1:0] wa, input logic [1:0] ra,
                        input logic [1:0] dout, input logic [2:0] cnt);
        bus.wr_req = wr;
        bus.rd_req = rd;
        d_in       = din;
        @(negedge clk);
        chk("ram_en_wr", {7'd0, bus.ram_en_wr}, {7'd0, ew});
        chk("ram_en_rd", {7'd0, bus.ram_en_rd}, {7'd0, er});
        chk("ram_addr_wr", {6'd0, bus.ram_addr_wr}, {6'd0, wa});
        chk("ram_addr_rd", {6'd0, bus.ram_addr_rd}, {6'd0, ra});
        if (er) exp_q.push_back(dout);
        @(posedge clk);
        #1;
        chk("count", {5'd0, bus.count}, {5'd0, cnt});
        chk("full", {7'd0, bus.full}, {7'd0, (cnt == 3'd4)});
        chk("empty", {7'd0, bus.empty}, {7'd0, (cnt == 3'd0)});
        chk("rd_valid", {7'd0, bus.rd_valid}, {7'd0, er});
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
    endtask

    initial begin
        // 1. Reset for two cycles with both requests asserted.
        rst_n      = 1'b0;
        bus.wr_req = 1'b1;
        bus.rd_req = 1'b1;
        d_in       = 2'd0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_en_wr", {7'd0, bus.ram_en_wr}, 8'd0);
        chk("rst_en_rd", {7'd0, bus.ram_en_rd}, 8'd0);
        @(posedge clk);
        #1;
        chk("rst_count", {5'd0, bus.count}, 8'd0);
        chk("rst_empty", {7'd0, bus.empty}, 8'd1);
        chk("rst_full", {7'd0, bus.full}, 8'd0);
        chk("rst_rd_valid", {7'd0, bus.rd_valid}, 8'd0);
        rst_n      = 1'b1;
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;

        // 2. Fill with 1,2,3,0 then one rejected push.
        step(1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 3'd1);
        step(1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 2'd1, 2'd0, 2'd0, 3'd2);
        step(1'b1, 1'b0, 2'd3, 1'b1, 1'b0, 2'd2, 2'd0, 2'd0, 3'd3);
        step(1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 2'd3, 2'd0, 2'd0, 3'd4);
        step(1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd4);
`ifdef FIFO_CTRL_ERR_FLAGS_EN
        chk("overflow", {7'd0, bus.overflow}, 8'd1);
        chk("underflow_clear", {7'd0, bus.underflow}, 8'd0);
`endif

        // 3. Drain 1,2,3,0 then one rejected pop.
        step(1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd1, 3'd3);
        step(1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 2'd0, 2'd1, 2'd2, 3'd2);
        step(1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 2'd0, 2'd2, 2'd3, 3'd1);
        step(1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 2'd0, 2'd3, 2'd0, 3'd0);
        step(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 3'd0);
`ifdef FIFO_CTRL_ERR_FLAGS_EN
        chk("underflow", {7'd0, bus.underflow}, 8'd1);
`endif

        // 4. Simultaneous push+pop from EMPTY, at COUNT=2, and from FULL.
        step(1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 3'd1);
        step(1'b1, 1'b0, 2'd3, 1'b1, 1'b0, 2'd1, 2'd0, 2'd0, 3'd2);
        step(1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 2'd2, 2'd0, 2'd2, 3'd2);
        step(1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 2'd3, 2'd1, 2'd0, 3'd3);
        step(1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 2'd0, 2'd1, 2'd0, 3'd4);
        step(1'b1, 1'b1, 2'd3, 1'b0, 1'b1, 2'd1, 2'd1, 2'd3, 3'd3);
        // Drain remaining 1,0,2.
        step(1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 2'd1, 2'd2, 2'd1, 3'd2);
        step(1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 2'd1, 2'd3, 2'd0, 3'd1);
        step(1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 2'd1, 2'd0, 2'd2, 3'd0);

        // 5. Wrap: six push/pop pairs, addresses 1,2,3,0,1,2.
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 1'b0, 2'((k + 2) % 4), 1'b1, 1'b0,
                 2'((k + 1) % 4), 2'((k + 1) % 4), 2'd0, 3'd1);
            step(1'b0, 1'b1, 2'd0, 1'b0, 1'b1,
                 2'((k + 2) % 4), 2'((k + 1) % 4), 2'((k + 2) % 4), 3'd0);
        end

        // 6. Fill to three across the pointer wrap, then reset with a pop.
        step(1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 2'd3, 2'd3, 2'd0, 3'd1);
        step(1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 2'd0, 2'd3, 2'd0, 3'd2);
        step(1'b1, 1'b0, 2'd3, 1'b1, 1'b0, 2'd1, 2'd3, 2'd0, 3'd3);
        bus.rd_req = 1'b1;
        rst_n      = 1'b0;
        @(negedge clk);
        chk("midrst_en_rd", {7'd0, bus.ram_en_rd}, 8'd0);
        @(posedge clk);
        #1;
        chk("midrst_rd_valid", {7'd0, bus.rd_valid}, 8'd0);
        chk("midrst_count", {5'd0, bus.count}, 8'd0);
        chk("midrst_empty", {7'd0, bus.empty}, 8'd1);
        chk("midrst_full", {7'd0, bus.full}, 8'd0);
        rst_n      = 1'b1;
        bus.rd_req = 1'b0;
`ifdef FIFO_CTRL_ERR_FLAGS_EN
        chk("midrst_overflow", {7'd0, bus.overflow}, 8'd0);
        chk("midrst_underflow", {7'd0, bus.underflow}, 8'd0);
`endif
        // Contents discarded: pointers restart at address 0.
        step(1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 3'd1);
        step(1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 2'd1, 2'd0, 2'd2, 3'd0);

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 8'(exp_q.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
